// File: rtl/vs_rr_arbiter.sv
// vs_rr_arbiter
//
// Merges N upstream valid/stall channels into one downstream valid/stall
// channel.  Every requester owns a small FIFO of 2^K entries; arbitration
// is round-robin and packet-atomic.  Once a multi-beat packet has started,
// its source stays locked until the beat with last=1 has been sent.
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : asynchronous reset, active low
//   valid_us  : [N] beat offered by requester i
//   data_us   : [N][WIDTH] payload per requester
//   last_us   : [N] final beat of a packet
//   stall_us  : [N] registered backpressure per requester
//   valid_ds  : beat presented downstream (transfers when high)
//   data_ds   : granted payload, 0 when idle
//   last_ds   : granted beat closes its packet, 0 when idle
//   src_ds    : index of the granted requester, 0 when idle
//   stall_ds  : downstream cannot accept this cycle
module vs_rr_arbiter #(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int K     = 2,
  localparam int SW   = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             valid_us,
  input  logic [N-1:0][WIDTH-1:0]  data_us,
  input  logic [N-1:0]             last_us,
  output logic [N-1:0]             stall_us,
  output logic                     valid_ds,
  output logic [WIDTH-1:0]         data_ds,
  output logic                     last_ds,
  output logic [SW-1:0]            src_ds,
  input  logic                     stall_ds
);

  localparam int DEPTH = 1 << K;

  typedef logic [K:0] ptr_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  // Each entry stores {last, data}.
  logic [WIDTH:0] mem [N][DEPTH];
  ptr_t           wr_ptr   [N];
  ptr_t           rd_ptr   [N];
  ptr_t           occ_next [N];

  state_t         state;
  logic [SW-1:0]  rr_ptr;
  logic [SW-1:0]  owner;

  logic [N-1:0]   not_empty;
  logic [N-1:0]   push;
  logic [N-1:0]   pop;
  logic           grant_found;
  logic [SW-1:0]  grant;
  logic [WIDTH:0] head;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      not_empty[i] = (wr_ptr[i] != rd_ptr[i]);
      push[i]      = valid_us[i] & ~stall_us[i];
    end
  end

  // In IDLE the search starts just after the last packet's winner, so the
  // most recently served port has lowest priority.  In LOCKED only the
  // owner may be granted, even if it is momentarily empty.
  always_comb begin
    int            cand;
    logic [SW-1:0] idx;
    grant_found = 1'b0;
    grant       = '0;
    cand        = 0;
    idx         = '0;
    if (state == LOCKED) begin
      grant       = owner;
      grant_found = not_empty[owner];
    end else begin
      for (int off = 1; off <= N; off++) begin
        cand = int'(rr_ptr) + off;
        if (cand >= N) cand = cand - N;
        idx = SW'(cand);
        if (!grant_found && not_empty[idx]) begin
          grant_found = 1'b1;
          grant       = idx;
        end
      end
    end
  end

  assign head     = mem[grant][rd_ptr[grant][K-1:0]];
  assign valid_ds = ~stall_ds & grant_found;
  assign data_ds  = valid_ds ? head[WIDTH-1:0] : '0;
  assign last_ds  = valid_ds & head[WIDTH];
  assign src_ds   = valid_ds ? grant : '0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pop[i]      = valid_ds && (grant == SW'(i));
      occ_next[i] = wr_ptr[i] - rd_ptr[i] + ptr_t'(push[i]) - ptr_t'(pop[i]);
    end
  end

  // Storage carries no reset; emptiness is defined purely by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i][K-1:0]] <= {last_us[i], data_us[i]};
    end
  end

  // stall_us asserts one slot early (at 2^K-1) because it only reaches the
  // upstream a cycle later; this keeps the FIFO from ever overflowing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      stall_us <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_t'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + ptr_t'(1);
        stall_us[i] <= (occ_next[i] >= ptr_t'(DEPTH - 1));
      end
    end
  end

  // Arbitration state only moves on an actual transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= SW'(N - 1);
      owner  <= '0;
    end else if (valid_ds) begin
      if (state == IDLE) begin
        if (last_ds) begin
          rr_ptr <= grant;
        end else begin
          state <= LOCKED;
          owner <= grant;
        end
      end else if (last_ds) begin
        state  <= IDLE;
        rr_ptr <= owner;
      end
    end
  end

endmodule

// File: tb/tb_vs_rr_arbiter.sv
// Testbench for vs_rr_arbiter.  Accepted upstream beats are pushed into a
// per-port expected queue; every downstream transfer pops the queue of the
// reported source and compares payload and last flag.
module tb_vs_rr_arbiter;

  localparam int N     = 3;
  localparam int WIDTH = 8;
  localparam int K     = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N-1:0]            valid_us = '0;
  logic [N-1:0][WIDTH-1:0] data_us = '0;
  logic [N-1:0]            last_us = '0;
  logic [N-1:0]            stall_us;
  logic                    valid_ds;
  logic [WIDTH-1:0]        data_ds;
  logic                    last_ds;
  logic [1:0]              src_ds;
  logic                    stall_ds = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  logic             obs_valid;
  logic [1:0]       obs_src;
  logic [WIDTH-1:0] obs_data;
  logic             obs_last;
  logic [N-1:0]     obs_stall;

  vs_rr_arbiter #(.N(N), .WIDTH(WIDTH), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_us (valid_us),
    .data_us  (data_us),
    .last_us  (last_us),
    .stall_us (stall_us),
    .valid_ds (valid_ds),
    .data_ds  (data_ds),
    .last_ds  (last_ds),
    .src_ds   (src_ds),
    .stall_ds (stall_ds)
  );

  always #5 clk = ~clk;

  // One clock cycle: sample outputs mid-cycle, score the transfer, record
  // the beats the DUT will accept on the coming edge, then step past it.
  task automatic tick();
    logic [8:0] exp_beat;
    logic       have;
    @(negedge clk);
    obs_valid = valid_ds;
    obs_src   = src_ds;
    obs_data  = data_ds;
    obs_last  = last_ds;
    obs_stall = stall_us;
    have      = 1'b0;
    exp_beat  = '0;
    tests++;
    if (valid_ds) begin
      case (src_ds)
        2'd0: if (q0.size() > 0) begin exp_beat = q0.pop_front(); have = 1'b1; end
        2'd1: if (q1.size() > 0) begin exp_beat = q1.pop_front(); have = 1'b1; end
        2'd2: if (q2.size() > 0) begin exp_beat = q2.pop_front(); have = 1'b1; end
        default: have = 1'b0;
      endcase
      if (!have) begin
        fails++;
        $display("[TB] FAIL sb_unexpected: got src=%0d beat=%h, expected no transfer from that port",
                 src_ds, {last_ds, data_ds});
      end else if ({last_ds, data_ds} !== exp_beat) begin
        fails++;
        $display("[TB] FAIL sb_beat src=%0d: got %h, expected %h", src_ds, {last_ds, data_ds}, exp_beat);
      end
    end else if (data_ds !== '0 || last_ds !== 1'b0 || src_ds !== '0) begin
      fails++;
      $display("[TB] FAIL idle_outputs: got data=%h last=%b src=%0d, expected all 0",
               data_ds, last_ds, src_ds);
    end
    if (rst) begin
      if (valid_us[0] && !stall_us[0]) q0.push_back({last_us[0], data_us[0]});
      if (valid_us[1] && !stall_us[1]) q1.push_back({last_us[1], data_us[1]});
      if (valid_us[2] && !stall_us[2]) q2.push_back({last_us[2], data_us[2]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_us = '0;
    data_us  = '0;
    last_us  = '0;
    stall_ds = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input int cycles);
    clear_inputs();
    for (int c = 0; c < cycles; c++) tick();
    tests++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain_empty: got %0d/%0d/%0d beats outstanding, expected 0/0/0",
               q0.size(), q1.size(), q2.size());
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    valid_us = '1;
    data_us  = {8'hC3, 8'hB2, 8'hA1};
    last_us  = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if (obs_valid !== 1'b0 || obs_stall !== '0) begin
        fails++;
        $display("[TB] FAIL reset_outputs: got valid=%b stall_us=%b, expected 0/000", obs_valid, obs_stall);
      end
    end
    clear_inputs();
    rst = 1'b1;
    valid_us[1] = 1'b1;
    data_us[1]  = 8'h5A;
    last_us[1]  = 1'b1;
    tick();
    tests++;
    if (obs_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL first_beat_bypass: got valid=%b, expected 0", obs_valid);
    end
    clear_inputs();
    tick();
    tests++;
    if (obs_valid !== 1'b1 || obs_src !== 2'd1 || obs_data !== 8'h5A || obs_last !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_beat: got valid=%b src=%0d data=%h last=%b, expected 1/1/5a/1",
               obs_valid, obs_src, obs_data, obs_last);
    end
    drain(3);
  endtask

  task automatic test_round_robin();
    int           seq [N];
    logic [N-1:0] acc;
    int           exp_src;
    reset_dut();
    for (int p = 0; p < N; p++) seq[p] = 0;
    exp_src = 0;
    for (int c = 0; c < 15; c++) begin
      valid_us = '1;
      last_us  = '1;
      for (int p = 0; p < N; p++) data_us[p] = 8'(16 * (p + 1) + (seq[p] % 16));
      acc = valid_us & ~stall_us;
      tick();
      for (int p = 0; p < N; p++) if (acc[p]) seq[p]++;
      if (c >= 1) begin
        tests++;
        if (obs_valid !== 1'b1 || obs_src !== 2'(exp_src)) begin
          fails++;
          $display("[TB] FAIL rr_order cycle %0d: got valid=%b src=%0d, expected 1/%0d",
                   c, obs_valid, obs_src, exp_src);
        end
        exp_src = (exp_src + 1) % N;
      end
    end
    drain(12);
  endtask

  task automatic test_packet_lock();
    logic       exp_v [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         exp_s [11] = '{0, 0, 2, 2, 2, 0, 2, 0, 0, 2, 0};
    logic       p2_v  [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       p2_l  [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] p2_d  [11] = '{8'h21, 8'h22, 8'h23, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h25, 8'h00, 8'h00};
    int         seq0;
    logic       acc0;
    reset_dut();
    seq0 = 0;
    for (int c = 0; c < 11; c++) begin
      valid_us[0] = 1'b1;
      last_us[0]  = 1'b1;
      data_us[0]  = 8'(8'hA0 + (seq0 % 16));
      valid_us[2] = p2_v[c];
      last_us[2]  = p2_l[c];
      data_us[2]  = p2_d[c];
      acc0 = valid_us[0] & ~stall_us[0];
      tick();
      if (acc0) seq0++;
      tests++;
      if (obs_valid !== exp_v[c] || (exp_v[c] && obs_src !== 2'(exp_s[c]))) begin
        fails++;
        $display("[TB] FAIL lock cycle %0d: got valid=%b src=%0d, expected valid=%b src=%0d",
                 c, obs_valid, obs_src, exp_v[c], exp_s[c]);
      end
    end
    drain(8);
  endtask

  task automatic test_backpressure();
    int   seq0;
    logic acc0;
    reset_dut();
    seq0     = 0;
    stall_ds = 1'b1;
    for (int c = 0; c < 10; c++) begin
      valid_us[0] = 1'b1;
      last_us[0]  = 1'b1;
      data_us[0]  = 8'(8'h40 + seq0);
      acc0 = valid_us[0] & ~stall_us[0];
      tick();
      if (acc0) seq0++;
      tests++;
      if (obs_valid !== 1'b0 || obs_stall[0] !== (c >= 3)) begin
        fails++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b stall_us0=%b, expected 0/%b",
                 c, obs_valid, obs_stall[0], (c >= 3));
      end
    end
    tests++;
    if (seq0 != 3) begin
      fails++;
      $display("[TB] FAIL bp_occupancy: got %0d beats accepted, expected 3", seq0);
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (obs_valid !== (c < 3) || (c < 3 && obs_data !== 8'(8'h40 + c))) begin
        fails++;
        $display("[TB] FAIL bp_drain cycle %0d: got valid=%b data=%h, expected %b/%h",
                 c, obs_valid, obs_data, (c < 3), 8'(8'h40 + c));
      end
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int c = 0; c < 41; c++) begin
      valid_us[1] = (c < 40);
      last_us[1]  = 1'b1;
      data_us[1]  = 8'(c);
      tick();
      tests++;
      if (obs_stall !== '0) begin
        fails++;
        $display("[TB] FAIL wrap_stall cycle %0d: got stall_us=%b, expected 000", c, obs_stall);
      end
      if (c >= 1) begin
        tests++;
        if (obs_valid !== 1'b1 || obs_src !== 2'd1 || obs_data !== 8'(c - 1)) begin
          fails++;
          $display("[TB] FAIL wrap_beat cycle %0d: got valid=%b src=%0d data=%h, expected 1/1/%h",
                   c, obs_valid, obs_src, obs_data, 8'(c - 1));
        end
      end
    end
    drain(2);
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      valid_us[1] = 1'b1;
      last_us[1]  = 1'b0;
      data_us[1]  = 8'(8'h60 + c);
      if (c == 1) begin
        valid_us[0] = 1'b1;
        last_us[0]  = 1'b1;
        data_us[0]  = 8'h30;
      end
      tick();
      if (c >= 1) begin
        tests++;
        if (obs_valid !== 1'b1 || obs_src !== 2'd1) begin
          fails++;
          $display("[TB] FAIL mid_pre cycle %0d: got valid=%b src=%0d, expected 1/1", c, obs_valid, obs_src);
        end
      end
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    tests++;
    if (valid_ds !== 1'b0 || data_ds !== '0 || last_ds !== 1'b0 || src_ds !== '0 || stall_us !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs: got valid=%b data=%h last=%b src=%0d stall_us=%b, expected all 0",
               valid_ds, data_ds, last_ds, src_ds, stall_us);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    valid_us = 3'b011;
    last_us  = 3'b011;
    data_us[0] = 8'h33;
    data_us[1] = 8'h77;
    tick();
    clear_inputs();
    for (int c = 1; c < 4; c++) begin
      tick();
      tests++;
      if ((c == 1 && (obs_valid !== 1'b1 || obs_src !== 2'd0 || obs_data !== 8'h33)) ||
          (c == 2 && (obs_valid !== 1'b1 || obs_src !== 2'd1 || obs_data !== 8'h77)) ||
          (c == 3 && obs_valid !== 1'b0)) begin
        fails++;
        $display("[TB] FAIL mid_after cycle %0d: got valid=%b src=%0d data=%h, expected %s",
                 c, obs_valid, obs_src, obs_data,
                 (c == 1) ? "1/0/33" : ((c == 2) ? "1/1/77" : "valid 0"));
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vs_rr_arbiter.md
# vs_rr_arbiter

Merges N upstream valid/stall channels into a single downstream valid/stall channel. Each input has its own small FIFO, and arbitration is round-robin and packet-atomic. The block sits in front of a shared pipeline stage, such as a single intersection or shading unit fed by several ray sources. Upstream ports use the codebase valid/stall protocol with a registered stall, and the downstream port is gated combinationally by `stall_ds`.

## Interface
- `N`, default 3: number of requesters, N ≥ 2.
- `WIDTH`, default 8: payload width.
- `K`, default 2: per-input FIFO depth is 2^K entries, K ≥ 1.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `valid_us` input [N-1:0]: beat offered by requester i.
- `data_us` input [N-1:0][WIDTH-1:0]: payload per requester.
- `last_us` input [N-1:0]: final beat of a packet.
- `stall_us` output [N-1:0]: registered backpressure per requester.
- `valid_ds` output 1: beat presented downstream.
- `data_ds` output [WIDTH-1:0]: granted payload.
- `last_ds` output 1: granted beat is the final beat of its packet.
- `src_ds` output [$clog2(N)-1:0]: index of the granted requester.
- `stall_ds` input 1: downstream cannot accept this cycle.

## Operation
- **Push rule.** In any cycle where `valid_us[i]`=1 and `stall_us[i]`=0, the beat {`last_us[i]`, `data_us[i]`} is written into FIFO i unconditionally. A beat offered while `stall_us[i]`=1 is ignored; the upstream holds it.
- **stall_us register.** `stall_us[i]` is registered: it takes (occupancy_next[i] ≥ 2^K−1). FIFO i therefore never overflows, and its maximum occupancy is 2^K−1.
- **valid_ds.** `valid_ds` = !`stall_ds` & (a grantable FIFO is non-empty). A beat transfers exactly when `valid_ds`=1, and the granted FIFO pops in that cycle.
- **Idle outputs.** When `valid_ds`=0, `data_ds`, `last_ds` and `src_ds` drive 0.
- **FSM state IDLE.** The grant goes to the first non-empty FIFO searching upward from rr_ptr+1, modulo N. On transfer:
  - if `last`=0: go to LOCKED with owner = winner;
  - if `last`=1: stay IDLE and set rr_ptr = winner.
- **FSM state LOCKED(owner).** Only FIFO owner is grantable. If it is empty, `valid_ds`=0 even when other FIFOs hold data. When the owner's beat with `last`=1 transfers, go to IDLE and set rr_ptr = owner.
- **stall_ds=1.** No grant, no pop, and the state and rr_ptr hold.
- **Simultaneous push and pop** on the same FIFO in one cycle is legal; occupancy is unchanged. A push into an empty FIFO is not bypassed: it is visible at the head in the next cycle.
- **Pointers.** FIFO pointers are K+1 bits and wrap modulo 2^(K+1). Empty is ptr equality.
- **Reset values.** FIFOs empty, FSM = IDLE, rr_ptr = N−1 (port 0 has first priority), `stall_us` = 0, `valid_ds`/`data_ds`/`last_ds`/`src_ds` = 0.
- **Reset mid-operation.** Reset asserted mid-packet discards all FIFO contents and the lock immediately (asynchronous). No partial-packet recovery.

## Timing
- **Minimum latency.** A beat pushed in cycle t appears on `valid_ds` in cycle t+1 at the earliest.
- **Stall reaction.** `stall_us[i]` reacts one cycle after the occupancy change that causes it.
- **Downstream gating.** `stall_ds` → `valid_ds` is a combinational path; all other outputs depend on registered state and `stall_ds` only.
- **Throughput.** One beat per cycle downstream when `stall_ds`=0 and a grantable FIFO is non-empty.
- **Fairness.** With all N requesters sending single-beat packets continuously, grants rotate 0,1,…,N−1,0…; each requester waits at most N−1 packets.

## Test plan
- **Reset and first beat.** Hold reset low, then release. Push port 1 data 0x5A with last=1 in cycle 0. Expect in cycle 1: `valid_ds`=1, `data_ds`=0x5A, `src_ds`=1, `last_ds`=1. All outputs are 0 during reset.
- **Round robin.** All three ports push single-beat packets (data 0x10+i) every cycle. Expect `src_ds` to sequence 0,1,2,0,1,2 and the `stall_us` pattern to stay periodic. No beat is lost or duplicated (scoreboard).
- **Packet lock.** Port 2 sends 3 beats, last on the 3rd, while port 0 sends continuously. Expect `src_ds`=2 for three consecutive transfers, then 0. Insert an empty-FIFO gap in port 2's packet: `valid_ds` must drop and port 0 must not be served.
- **Backpressure.** K=2. Hold `stall_ds`=1 for 10 cycles while port 0 pushes every allowed cycle. Expect occupancy to peak at 3, `stall_us[0]`=1 from the cycle after occupancy reaches 3, and `valid_ds`=0 throughout. After release, expect 3 beats drained in order.
- **Simultaneous push/pop and wrap.** Single port, with `stall_ds`=0, pushes 40 beats continuously. Expect in-order output with 1-cycle latency, correct across pointer wrap, and `stall_us` never asserted.
- **Reset mid-packet.** Assert reset after 2 of 4 beats of a port-1 packet. Expect all outputs 0, and after release port 0 is served first (rr_ptr = N−1).
